// File: rtl/systolic_pass_ctrl.sv
// Pass sequencer for the affine-gap systolic array: replays the last-PE boundary column into PE0.
// Optional feature: define SYS_BEST_TRACK_EN to enable global best-score/position tracking.
module systolic_pass_ctrl #(
    parameter int N_PE    = 64,
    parameter int CW      = 16,
    parameter int AW      = 11,
    parameter int DEPTH   = 2048,
    parameter int PW      = 4,
    parameter int NEG_INF = -(2 ** (CW - 2))
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          new_seq,
    input  logic          ack,
    input  logic          feed_en,
    input  logic          last_valid,
    input  logic [AW-1:0] last_addr,
    input  logic [CW-1:0] last_h,
    input  logic [CW-1:0] last_f,
    input  logic [CW-1:0] last_fh,
    input  logic [CW-1:0] last_max,
    input  logic [AW-1:0] last_x,
    input  logic [AW-1:0] last_y,
    input  logic          end_valid,
    input  logic [CW-1:0] end_max,
    input  logic [AW-1:0] end_x,
    input  logic [AW-1:0] end_y,
    output logic [CW-1:0] pe0_h,
    output logic [CW-1:0] pe0_f,
    output logic [CW-1:0] pe0_fh,
    output logic [CW-1:0] pe0_max,
    output logic [AW-1:0] pe0_x,
    output logic [AW-1:0] pe0_y,
    output logic          load_en,
    output logic          busy,
    output logic          pe_rst_n,
    output logic          pass_done,
    output logic [PW-1:0] pass_idx,
    output logic [CW-1:0] best_score,
    output logic [AW-1:0] best_x,
    output logic [AW-1:0] best_y,
    output logic [1:0]    err
);

    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LCW = $clog2(N_PE + 1);
    localparam logic [CW-1:0] NegSeed = CW'(NEG_INF);
    localparam logic [PW-1:0] PassMax = '1;

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDone} state_e;

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] f;
        logic [CW-1:0] fh;
        logic [CW-1:0] mx;
        logic [AW-1:0] x;
        logic [AW-1:0] y;
    } entry_t;

    state_e           state_q, state_d;
    logic [LCW-1:0]   load_cnt_q, load_cnt_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             seen_q, seen_d;
    logic             lv_q;
    logic             fall_q, fall_d;
    logic             was_calc_q;
    logic [PW-1:0]    pass_idx_q, pass_idx_d;
    logic [1:0]       err_q, err_d;
    logic             addr_oob;
    logic             calc_first;
    logic             seq_clear;
    entry_t           mem [DEPTH];
    entry_t           rd_data;

    assign addr_oob   = {1'b0, last_addr} >= (AW + 1)'(DEPTH);
    assign calc_first = (state_q == StCalc) && !was_calc_q;
    assign seq_clear  = (state_q == StIdle) && new_seq;
    assign rd_data    = mem[rd_ptr_q[IW-1:0]];

    // State register
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ack) state_d = StLoad;
            StLoad: if (load_cnt_q == LCW'(N_PE - 1)) state_d = StCalc;
            StCalc: if (fall_q) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        load_en   = (state_q == StLoad);
        busy      = (state_q == StCalc);
        pe_rst_n  = (state_q != StDone);
        pass_done = (state_q == StDone);
        pe0_h     = '0;
        pe0_f     = '0;
        pe0_fh    = '0;
        pe0_max   = '0;
        pe0_x     = '0;
        pe0_y     = '0;
        if (state_q == StCalc) begin
            if (pass_idx_q == '0 || calc_first) begin
                pe0_f  = NegSeed;
                pe0_fh = NegSeed;
            end else begin
                pe0_h   = rd_data.h;
                pe0_f   = rd_data.f;
                pe0_fh  = rd_data.fh;
                pe0_max = rd_data.mx;
                pe0_x   = rd_data.x;
                pe0_y   = rd_data.y;
            end
        end
    end

    // Pass bookkeeping next-state
    always_comb begin
        load_cnt_d = (state_q == StLoad) ? load_cnt_q + 1'b1 : '0;
        rd_ptr_d   = '0;
        if (state_q == StCalc) begin
            rd_ptr_d = rd_ptr_q;
            if (feed_en) begin
                rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
        seen_d = (state_q == StCalc) && (seen_q || last_valid);
        // Fall is registered so DONE lands two cycles after last_valid drops
        fall_d = (state_q == StCalc) && seen_q && lv_q && !last_valid;

        pass_idx_d = pass_idx_q;
        err_d      = err_q;
        if (seq_clear) begin
            pass_idx_d = '0;
            err_d      = '0;
        end
        if (state_q == StDone) begin
            if (pass_idx_q == PassMax) begin
                err_d[1] = 1'b1;
            end else begin
                pass_idx_d = pass_idx_q + 1'b1;
            end
        end
        if (last_valid && addr_oob) begin
            err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            load_cnt_q <= '0;
            rd_ptr_q   <= '0;
            seen_q     <= 1'b0;
            lv_q       <= 1'b0;
            fall_q     <= 1'b0;
            was_calc_q <= 1'b0;
            pass_idx_q <= '0;
            err_q      <= '0;
        end else begin
            load_cnt_q <= load_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            seen_q     <= seen_d;
            lv_q       <= last_valid;
            fall_q     <= fall_d;
            was_calc_q <= (state_q == StCalc);
            pass_idx_q <= pass_idx_d;
            err_q      <= err_d;
        end
    end

    // Boundary-column ring buffer; contents survive reset, reads see pre-write data
    always_ff @(posedge clk) begin
        if (last_valid && !addr_oob) begin
            mem[last_addr[IW-1:0]] <= '{h: last_h, f: last_f, fh: last_fh, mx: last_max,
                                        x: last_x, y: last_y};
        end
    end

    assign pass_idx = pass_idx_q;
    assign err      = err_q;

`ifdef SYS_BEST_TRACK_EN
    logic [CW-1:0] best_score_q, best_score_d;
    logic [AW-1:0] best_x_q, best_x_d;
    logic [AW-1:0] best_y_q, best_y_d;

    always_comb begin
        best_score_d = best_score_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        if (seq_clear) begin
            best_score_d = '0;
            best_x_d     = '0;
            best_y_d     = '0;
        end else if (end_valid && ($signed(end_max) > $signed(best_score_q))) begin
            best_score_d = end_max;
            best_x_d     = end_x;
            best_y_d     = end_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            best_score_q <= '0;
            best_x_q     <= '0;
            best_y_q     <= '0;
        end else begin
            best_score_q <= best_score_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
        end
    end

    assign best_score = best_score_q;
    assign best_x     = best_x_q;
    assign best_y     = best_y_q;
`else
    logic unused_end;
    assign unused_end = ^{end_valid, end_max, end_x, end_y};
    assign best_score = '0;
    assign best_x     = '0;
    assign best_y     = '0;
`endif

endmodule

// File: tb/tb_systolic_pass_ctrl.sv
// Directed bench for systolic_pass_ctrl: handshake, replay, collision, saturation, reset, best.
module tb_systolic_pass_ctrl;

    localparam int N_PE  = 4;
    localparam int CW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 32;
    localparam int PW    = 2;
    localparam logic [CW-1:0] NEG = 16'hC000;

    logic          clk = 1'b0;
    logic          reset_i, new_seq, ack, feed_en, last_valid, end_valid;
    logic [AW-1:0] last_addr, last_x, last_y, end_x, end_y;
    logic [CW-1:0] last_h, last_f, last_fh, last_max, end_max;
    logic [CW-1:0] pe0_h, pe0_f, pe0_fh, pe0_max, best_score;
    logic [AW-1:0] pe0_x, pe0_y, best_x, best_y;
    logic          load_en, busy, pe_rst_n, pass_done;
    logic [PW-1:0] pass_idx;
    logic [1:0]    err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] mdl_h [DEPTH];
    logic [CW-1:0] mdl_f [DEPTH];
    logic [CW-1:0] exp_q [$];
    int mrd;
    int best_tbl [4] = '{3, 7, 7, -2};

    always #5 clk = ~clk;

    systolic_pass_ctrl #(
        .N_PE(N_PE), .CW(CW), .AW(AW), .DEPTH(DEPTH), .PW(PW)
    ) dut (
        .clk(clk), .reset_i(reset_i), .new_seq(new_seq), .ack(ack), .feed_en(feed_en),
        .last_valid(last_valid), .last_addr(last_addr), .last_h(last_h), .last_f(last_f),
        .last_fh(last_fh), .last_max(last_max), .last_x(last_x), .last_y(last_y),
        .end_valid(end_valid), .end_max(end_max), .end_x(end_x), .end_y(end_y),
        .pe0_h(pe0_h), .pe0_f(pe0_f), .pe0_fh(pe0_fh), .pe0_max(pe0_max),
        .pe0_x(pe0_x), .pe0_y(pe0_y), .load_en(load_en), .busy(busy), .pe_rst_n(pe_rst_n),
        .pass_done(pass_done), .pass_idx(pass_idx), .best_score(best_score),
        .best_x(best_x), .best_y(best_y), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_lv(input int addr, input int h, input int f);
        last_valid = 1'b1;
        last_addr  = AW'(addr);
        last_h     = CW'(h);
        last_f     = CW'(f);
        last_fh    = CW'(h + 1);
        last_max   = CW'(h);
        last_x     = AW'(addr);
        last_y     = AW'(addr + 1);
    endtask

    task automatic start_pass();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (N_PE) tick();
    endtask

    task automatic finish_pass(input string tag);
        logic got;
        got = 1'b0;
        last_valid = 1'b0;
        feed_en    = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (pass_done) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b0; new_seq = 1'b0; ack = 1'b0; feed_en = 1'b0; last_valid = 1'b0;
        last_addr = '0; last_h = '0; last_f = '0; last_fh = '0; last_max = '0;
        last_x = '0; last_y = '0; end_valid = 1'b0; end_max = '0; end_x = '0; end_y = '0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load_en", 32'(load_en), 32'd0);
        check("rst_pe_rst_n", 32'(pe_rst_n), 32'd1);
        check("rst_pass_idx", 32'(pass_idx), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_pe0_h", 32'(pe0_h), 32'd0);
        reset_i = 1'b1;
        tick();

        // Pass 0: handshake timing and boundary-column capture
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < N_PE; i++) begin
            check($sformatf("load_en_c%0d", i + 1), 32'(load_en), 32'd1);
            check($sformatf("busy_load_c%0d", i + 1), 32'(busy), 32'd0);
            tick();
        end
        check("load_en_end", 32'(load_en), 32'd0);
        check("busy_calc", 32'(busy), 32'd1);
        check("p0_first_h", 32'(pe0_h), 32'd0);
        check("p0_first_f", 32'(pe0_f), 32'(NEG));
        for (int k = 0; k < 10; k++) begin
            drive_lv(k, k + 5, k - 3);
            mdl_h[k] = CW'(k + 5);
            mdl_f[k] = CW'(k - 3);
            feed_en = 1'b1;
            if (k == 5) check("p0_seed_h", 32'(pe0_h), 32'd0);
            tick();
        end
        last_valid = 1'b0;
        feed_en    = 1'b0;
        tick();
        check("fall_plus1_done", 32'(pass_done), 32'd0);
        tick();
        check("fall_plus2_done", 32'(pass_done), 32'd1);
        check("done_pe_rst_n", 32'(pe_rst_n), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        tick();
        check("after_done_pulse", 32'(pass_done), 32'd0);
        check("after_done_pe_rst_n", 32'(pe_rst_n), 32'd1);
        check("pass_idx_1", 32'(pass_idx), 32'd1);
        check("idle_feed_h", 32'(pe0_h), 32'd0);

        // Pass 1: replay through the scoreboard, then a same-address collision
        start_pass();
        mrd = 0;
        for (int k = 0; k < 9; k++) begin
            feed_en = 1'b1;
            exp_q.push_back((k == 0) ? CW'(0) : mdl_h[mrd]);
            check($sformatf("replay_h_k%0d", k), 32'(pe0_h), 32'(exp_q.pop_front()));
            if (k == 0) check("replay_first_f", 32'(pe0_f), 32'(NEG));
            if (k == 3) check("replay_f_k3", 32'(pe0_f), 32'(mdl_f[mrd]));
            tick();
            mrd++;
        end
        feed_en = 1'b0;
        drive_lv(9, 200, 7);
        exp_q.push_back(mdl_h[mrd]);
        check("collide_old", 32'(pe0_h), 32'(exp_q.pop_front()));
        tick();
        mdl_h[9] = CW'(200);
        last_valid = 1'b0;
        exp_q.push_back(mdl_h[mrd]);
        check("collide_new", 32'(pe0_h), 32'(exp_q.pop_front()));
        finish_pass("pass1_done");
        check("pass_idx_2", 32'(pass_idx), 32'd2);

        // Out-of-range write is dropped and flagged
        drive_lv(DEPTH, 999, 0);
        tick();
        last_valid = 1'b0;
        check("err_oob", 32'(err), 32'd1);
        start_pass();
        feed_en = 1'b0;
        check("p2_first_h", 32'(pe0_h), 32'd0);
        tick();
        check("oob_dropped_h", 32'(pe0_h), 32'(mdl_h[0]));
        drive_lv(20, 1, 1);
        tick();
        finish_pass("pass2_done");
        check("pass_idx_3", 32'(pass_idx), 32'd3);
        check("err_no_sat_yet", 32'(err), 32'd1);

        // Fourth pass saturates the pass counter
        start_pass();
        drive_lv(21, 2, 2);
        tick();
        finish_pass("pass3_done");
        check("pass_idx_sat", 32'(pass_idx), 32'd3);
        check("err_sat", 32'(err), 32'd3);

        // Reset mid-CALC
        start_pass();
        drive_lv(22, 3, 3);
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset_i = 1'b0;
        tick();
        reset_i    = 1'b1;
        last_valid = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pass_idx", 32'(pass_idx), 32'd0);
        check("mid_rst_pe_rst_n", 32'(pe_rst_n), 32'd1);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_load_en", 32'(load_en), 32'd0);

        start_pass();
        drive_lv(23, 4, 4);
        tick();
        finish_pass("pass_after_rst_done");
        check("pass_idx_after_rst", 32'(pass_idx), 32'd1);

        // new_seq and ack together
        new_seq = 1'b1;
        ack     = 1'b1;
        tick();
        new_seq = 1'b0;
        ack     = 1'b0;
        check("newseq_pass_idx", 32'(pass_idx), 32'd0);
        check("newseq_load_en", 32'(load_en), 32'd1);

        for (int i = 0; i < 4; i++) begin
            end_valid = 1'b1;
            end_max   = CW'(best_tbl[i]);
            end_x     = AW'(i + 1);
            end_y     = AW'(i + 1);
            tick();
        end
        end_valid = 1'b0;
`ifdef SYS_BEST_TRACK_EN
        check("best_score", 32'(best_score), 32'd7);
        check("best_x", 32'(best_x), 32'd2);
        check("best_y", 32'(best_y), 32'd2);
`else
        check("best_score_off", 32'(best_score), 32'd0);
        check("best_x_off", 32'(best_x), 32'd0);
`endif
        new_seq = 1'b1;
        tick();
        new_seq = 1'b0;
        check("newseq_ignored_busy", 32'(busy), 32'd1);
`ifdef SYS_BEST_TRACK_EN
        check("newseq_ignored_best", 32'(best_score), 32'd7);
`endif
        drive_lv(24, 5, 5);
        tick();
        finish_pass("best_pass_done");
        new_seq = 1'b1;
        tick();
        new_seq = 1'b0;
        check("newseq_clear_best", 32'(best_score), 32'd0);
        check("newseq_clear_idx", 32'(pass_idx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
